ex_muldiv_sub: RTL and testbench
================================

Name: ex_muldiv_sub

Overview:
Parametrised execute sub-stage for the HI/LO class of instructions: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. It sits beside the single-cycle ALU sub-stage and owns the architectural HI/LO registers. Multiply is pipelined over a configurable latency; divide is a multi-cycle signed/unsigned restoring iterator. The block uses valid/ready handshakes on both sides, a forwarding bus, and flush abort.

Parameters:
DATA_W, 32, operand/HI/LO width
MUL_LAT, 2, multiply latency in cycles from accept to out_valid (>=1)
DIV_BITS, 1, quotient bits resolved per divide iteration (1, 2 or 4; must divide DATA_W)

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  kill in-flight op and output (exception/mispredict)
in_valid  in  1  upstream op valid
in_ready  out  1  block can accept
in_op  in  8  one-hot {MTLO,MTHI,MFLO,MFHI,DIVU,DIV,MULTU,MULT}
in_src1  in  DATA_W  rs value (dividend / multiplicand / MT source)
in_src2  in  DATA_W  rt value
in_dest  in  5  GPR dest (MFHI/MFLO only)
in_pc  in  32  instruction pc
out_valid  out  1  result/retire valid
out_ready  in  1  downstream accepts
out_gr_we  out  1  1 only for MFHI/MFLO
out_dest  out  5  GPR dest
out_result  out  DATA_W  MF value, else 0
out_pc  out  32  pc of retiring op
fwd_valid  out  1  = out_valid & out_gr_we
fwd_dest  out  5  = out_dest
fwd_result  out  DATA_W  = out_result
busy  out  1  FSM not IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; HI=LO=0; out_valid=0; out_gr_we=0; out_dest=0; out_result=0; out_pc=0; busy=0.
- FSM states: IDLE, MUL, DIV, DONE.
- in_ready = (state==IDLE) & (!out_valid | out_ready) & !flush. An op is accepted on an edge where in_valid & in_ready.
- in_op not one-hot or all-zero: the op is accepted and retires as a NOP (out_gr_we=0; HI/LO unchanged).
- MFHI/MFLO/MTHI/MTLO: single-cycle.
  - Accepted at edge T: out_valid=1 from T.
  - MFx: out_result = HI/LO sampled at T.
  - MTx: the write to HI/LO lands at T.
  - FSM stays IDLE.
- MULT/MULTU:
  - Accepted at T: state=MUL with a counter.
  - Product is 2*DATA_W bits, signed or unsigned per op.
  - At edge T+MUL_LAT: {HI,LO}=product, out_valid=1, state=DONE.
- DIV/DIVU:
  - Accepted at T: the setup cycle latches |src1| and |src2| plus the sign flags, then state=DIV.
  - DATA_W/DIV_BITS iterations follow.
  - Sign fixup happens on the last edge: quotient negated if the signs differ; remainder takes the dividend's sign.
  - Completion edge is T+1+DATA_W/DIV_BITS (T+33 at defaults): HI=remainder, LO=quotient, out_valid=1, state=DONE.
- Divide by zero: no fixup. LO = all ones, HI = src1; latency unchanged.
- DIV of most-negative by -1: LO = 0x80000000, HI = 0 (DATA_W=32).
- DONE -> IDLE on the next edge. Output hold is governed by out_valid/out_ready, not by the FSM.
- Output register:
  - Holds all out_* fields stable while out_valid & !out_ready.
  - Clears out_valid on out_ready unless a new result loads on the same edge.
- MUL/DIV outputs: out_gr_we=0, out_result=0, out_pc = accepted pc.
- Back-pressure at completion: a MUL/DIV completion cannot be blocked. in_ready already required the output slot to be free at accept, and no other op is in flight.
- Flush (sampled on the edge):
  - state=IDLE; out_valid=0; out_gr_we=0.
  - In-flight MUL/DIV is discarded with no HI/LO write, including when flush coincides with the completion edge.
  - An MTx accepted on an earlier edge is not undone.
  - in_ready=0 during the flush cycle, so no accept occurs then.
- Simultaneous out_ready and accept on the same edge: the old result retires and the new op is taken. A single-cycle new op loads into the output register on that edge.
- busy=1 in MUL, DIV and DONE. The issue stage uses it to stall MF/MT hazards.

Test Plan:
- MULT src1=0xFFFFFFFF, src2=0x00000002, accept at T -> out_valid at T+2, HI=0xFFFFFFFF, LO=0xFFFFFFFE. Then MFLO -> out_result=0xFFFFFFFE, out_gr_we=1, fwd_valid=1.
- DIVU 100/7 -> out_valid at T+33, LO=14, HI=2. DIV 0xFFFFFFF9/2 (-7/2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
- MTHI 0x1234, DIV started, flush at T+10 -> no out_valid; busy=0 and in_ready=1 next cycle; MFHI returns 0x1234. Repeat with flush on the T+33 edge -> same result.
- MFLO with out_ready=0 for 3 cycles -> out_* stable and in_ready=0. out_ready=1 together with in_valid(MTLO) -> both handshakes complete on one edge.
- Assert reset mid-divide at T+5 -> all outputs zero immediately (async); HI=LO=0 after release.

Source files
------------

// File: rtl/ex_muldiv_sub.sv
// HI/LO execute sub-stage: pipelined multiply, iterative restoring divide and MF/MT moves.
// Owns the architectural HI/LO pair; at most one op in flight, valid/ready on both sides.
module ex_muldiv_sub #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MUL_LAT  = 2,
  parameter int unsigned DIV_BITS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_op,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [4:0]        in_dest,
  input  logic [31:0]       in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_gr_we,
  output logic [4:0]        out_dest,
  output logic [DATA_W-1:0] out_result,
  output logic [31:0]       out_pc,
  output logic              fwd_valid,
  output logic [4:0]        fwd_dest,
  output logic [DATA_W-1:0] fwd_result,
  output logic              busy
);

  localparam int unsigned PROD_W    = 2 * DATA_W;
  localparam int unsigned DIV_ITERS = DATA_W / DIV_BITS;
  localparam int unsigned CNT_MAX   = (MUL_LAT > DIV_ITERS) ? MUL_LAT : DIV_ITERS;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              setup_q, setup_d;
  logic              sgn_q, sgn_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [31:0]       pc_q, pc_d;
  logic              out_valid_q, out_valid_d;
  logic              out_gr_we_q, out_gr_we_d;
  logic [4:0]        out_dest_q, out_dest_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic [31:0]       out_pc_q, out_pc_d;

  logic              accept_c, onehot_c, is_mf_c;
  logic              a_neg_c, b_neg_c;
  logic [DATA_W-1:0] abs_a_c, abs_b_c;
  logic [DATA_W:0]   rem_step_c;
  logic [DATA_W-1:0] quo_step_c, quo_fix_c, rem_fix_c;
  logic [PROD_W-1:0] mul_a_c, mul_b_c, prod_c;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready) && !flush;
  assign accept_c = in_valid && in_ready;
  assign onehot_c = (in_op != 8'd0) && ((in_op & (in_op - 8'd1)) == 8'd0);
  assign is_mf_c  = onehot_c && (in_op[4] || in_op[5]);

  // Operand magnitudes for the divide setup cycle
  assign a_neg_c = sgn_q & op_a_q[DATA_W-1];
  assign b_neg_c = sgn_q & op_b_q[DATA_W-1];
  assign abs_a_c = a_neg_c ? (~op_a_q + DATA_W'(1)) : op_a_q;
  assign abs_b_c = b_neg_c ? (~op_b_q + DATA_W'(1)) : op_b_q;

  // Low 2W bits of the extended product are correct for both signed and unsigned
  assign mul_a_c = {{DATA_W{sgn_q & op_a_q[DATA_W-1]}}, op_a_q};
  assign mul_b_c = {{DATA_W{sgn_q & op_b_q[DATA_W-1]}}, op_b_q};
  assign prod_c  = mul_a_c * mul_b_c;

  // One divide iteration: DIV_BITS restoring shift-subtract steps on the magnitudes
  always_comb begin : div_step
    rem_step_c = {1'b0, rem_q};
    quo_step_c = quo_q;
    for (int unsigned i = 0; i < DIV_BITS; i++) begin
      rem_step_c = {rem_step_c[DATA_W-1:0], quo_step_c[DATA_W-1]};
      quo_step_c = {quo_step_c[DATA_W-2:0], 1'b0};
      if (rem_step_c >= {1'b0, op_b_q}) begin
        rem_step_c    = rem_step_c - {1'b0, op_b_q};
        quo_step_c[0] = 1'b1;
      end
    end
  end

  assign quo_fix_c = qneg_q ? (~quo_step_c + DATA_W'(1)) : quo_step_c;
  assign rem_fix_c = rneg_q ? (~rem_step_c[DATA_W-1:0] + DATA_W'(1)) : rem_step_c[DATA_W-1:0];

  always_comb begin : next_state
    state_d      = state_q;
    cnt_d        = cnt_q;
    setup_d      = setup_q;
    sgn_d        = sgn_q;
    qneg_d       = qneg_q;
    rneg_d       = rneg_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    pc_d         = pc_q;
    out_valid_d  = out_valid_q;
    out_gr_we_d  = out_gr_we_q;
    out_dest_d   = out_dest_q;
    out_result_d = out_result_q;
    out_pc_d     = out_pc_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (onehot_c && (in_op[0] || in_op[1])) begin
            state_d = S_MUL;
            cnt_d   = CNT_W'(MUL_LAT - 1);
            sgn_d   = in_op[0];
            op_a_d  = in_src1;
            op_b_d  = in_src2;
            pc_d    = in_pc;
          end else if (onehot_c && (in_op[2] || in_op[3])) begin
            state_d = S_DIV;
            cnt_d   = CNT_W'(DIV_ITERS);
            setup_d = 1'b1;
            sgn_d   = in_op[2];
            op_a_d  = in_src1;
            op_b_d  = in_src2;
            pc_d    = in_pc;
          end else begin
            // Moves and malformed encodings retire straight from the accept edge
            out_valid_d  = 1'b1;
            out_gr_we_d  = is_mf_c;
            out_dest_d   = is_mf_c ? in_dest : 5'd0;
            out_pc_d     = in_pc;
            out_result_d = '0;
            if (onehot_c && in_op[4]) out_result_d = hi_q;
            if (onehot_c && in_op[5]) out_result_d = lo_q;
            if (onehot_c && in_op[6]) hi_d = in_src1;
            if (onehot_c && in_op[7]) lo_d = in_src1;
          end
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = prod_c;
          state_d      = S_DONE;
          out_valid_d  = 1'b1;
          out_gr_we_d  = 1'b0;
          out_dest_d   = 5'd0;
          out_result_d = '0;
          out_pc_d     = pc_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DIV: begin
        if (setup_q) begin
          setup_d = 1'b0;
          op_b_d  = abs_b_c;
          quo_d   = abs_a_c;
          rem_d   = '0;
          qneg_d  = a_neg_c ^ b_neg_c;
          rneg_d  = a_neg_c;
        end else begin
          rem_d = rem_step_c[DATA_W-1:0];
          quo_d = quo_step_c;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d      = S_DONE;
            out_valid_d  = 1'b1;
            out_gr_we_d  = 1'b0;
            out_dest_d   = 5'd0;
            out_result_d = '0;
            out_pc_d     = pc_q;
            // Divide by zero skips sign fixup: quotient all ones, remainder is raw dividend
            if (op_b_q == '0) begin
              lo_d = '1;
              hi_d = op_a_q;
            end else begin
              lo_d = quo_fix_c;
              hi_d = rem_fix_c;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush kills anything in flight, including a completion on this same edge
    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      out_gr_we_d = 1'b0;
      hi_d        = hi_q;
      lo_d        = lo_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin : regs
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      setup_q      <= 1'b0;
      sgn_q        <= 1'b0;
      qneg_q       <= 1'b0;
      rneg_q       <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      pc_q         <= '0;
      out_valid_q  <= 1'b0;
      out_gr_we_q  <= 1'b0;
      out_dest_q   <= '0;
      out_result_q <= '0;
      out_pc_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      setup_q      <= setup_d;
      sgn_q        <= sgn_d;
      qneg_q       <= qneg_d;
      rneg_q       <= rneg_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      pc_q         <= pc_d;
      out_valid_q  <= out_valid_d;
      out_gr_we_q  <= out_gr_we_d;
      out_dest_q   <= out_dest_d;
      out_result_q <= out_result_d;
      out_pc_q     <= out_pc_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_gr_we  = out_gr_we_q;
  assign out_dest   = out_dest_q;
  assign out_result = out_result_q;
  assign out_pc     = out_pc_q;
  assign fwd_valid  = out_valid_q & out_gr_we_q;
  assign fwd_dest   = out_dest_q;
  assign fwd_result = out_result_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ex_muldiv_sub.sv
// Self-checking bench for ex_muldiv_sub: directed corner cases plus a randomized op stream
// compared against an arithmetic HI/LO reference model.
module tb_ex_muldiv_sub;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MUL_LAT  = 2;
  localparam int unsigned DIV_BITS = 1;
  localparam int          DIV_LAT  = 1 + DATA_W / DIV_BITS;

  localparam logic [7:0] OP_MULT  = 8'h01;
  localparam logic [7:0] OP_MULTU = 8'h02;
  localparam logic [7:0] OP_DIV   = 8'h04;
  localparam logic [7:0] OP_DIVU  = 8'h08;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MFLO  = 8'h20;
  localparam logic [7:0] OP_MTHI  = 8'h40;
  localparam logic [7:0] OP_MTLO  = 8'h80;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        in_op = 8'h00;
  logic [DATA_W-1:0] in_src1 = '0;
  logic [DATA_W-1:0] in_src2 = '0;
  logic [4:0]        in_dest = 5'd0;
  logic [31:0]       in_pc = 32'd0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_gr_we;
  logic [4:0]        out_dest;
  logic [DATA_W-1:0] out_result;
  logic [31:0]       out_pc;
  logic              fwd_valid;
  logic [4:0]        fwd_dest;
  logic [DATA_W-1:0] fwd_result;
  logic              busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  ex_muldiv_sub #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT), .DIV_BITS(DIV_BITS)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_dest(in_dest), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_gr_we(out_gr_we),
    .out_dest(out_dest), .out_result(out_result), .out_pc(out_pc),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_result(fwd_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: architectural effect of one op on HI/LO, its result and retire latency
  task automatic model_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic we, output int lat);
    logic [63:0] p;
    longint sa, sb;
    res = '0;
    we  = 1'b0;
    lat = 0;
    if ($countones(op) != 1) return;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  begin p = 64'(sa * sb); {hi_m, lo_m} = p; lat = MUL_LAT; end
      OP_MULTU: begin p = 64'(a) * 64'(b); {hi_m, lo_m} = p; lat = MUL_LAT; end
      OP_DIV: begin
        lat = DIV_LAT;
        if (b == 32'd0) begin lo_m = '1; hi_m = a; end
        else begin lo_m = 32'(sa / sb); hi_m = 32'(sa % sb); end
      end
      OP_DIVU: begin
        lat = DIV_LAT;
        if (b == 32'd0) begin lo_m = '1; hi_m = a; end
        else begin lo_m = a / b; hi_m = a % b; end
      end
      OP_MFHI: begin res = hi_m; we = 1'b1; end
      OP_MFLO: begin res = lo_m; we = 1'b1; end
      OP_MTHI: hi_m = a;
      OP_MTLO: lo_m = a;
      default: ;
    endcase
  endtask

  // Present an op, wait (bounded) for acceptance; returns at the negedge after the accept edge
  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dest, input logic [31:0] pc, input bit rnd);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    in_dest  = dest;
    in_pc    = pc;
    out_ready = rnd ? 1'($urandom) : 1'b1;
    #1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom) : 1'b1;
      #1;
      guard++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (rnd) out_ready = 1'($urandom);
  endtask

  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dest, input logic [31:0] pc, input bit rnd);
    logic [31:0] er;
    logic        ew;
    int          el;
    int          k = 0;
    model_op(op, a, b, er, ew, el);
    issue(op, a, b, dest, pc, rnd);
    chk("busy", 64'(busy), 64'(el > 0));
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 64'(k), 64'(el));
    chk("gr_we", 64'(out_gr_we), 64'(ew));
    chk("result", 64'(out_result), 64'(er));
    chk("pc", 64'(out_pc), 64'(pc));
    chk("fwd_valid", 64'(fwd_valid), 64'(ew));
    chk("fwd_result", 64'(fwd_result), 64'(er));
    if (ew) begin
      chk("dest", 64'(out_dest), 64'(dest));
      chk("fwd_dest", 64'(fwd_dest), 64'(dest));
    end
  endtask

  // Start a divide and flush it on edge accept+at; HI/LO must be untouched
  task automatic flush_div(input int at);
    issue(OP_DIV, 32'd1000, 32'd3, 5'd0, 32'h0000_0300, 1'b0);
    repeat (at - 1) @(negedge clk);
    chk("pre_flush_valid", 64'(out_valid), 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    repeat (40) @(negedge clk);
    chk("flush_no_late_valid", 64'(out_valid), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin : main
    logic [31:0] er;
    logic        ew;
    int          el;
    int          r;
    logic [7:0]  op;
    logic [7:0]  base;

    #2 reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_gr_we", 64'(out_gr_we), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    run_op(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0, 32'h0000_0100, 1'b0);
    run_op(OP_MFLO, 32'd0, 32'd0, 5'd3, 32'h0000_0104, 1'b0);
    run_op(OP_MFHI, 32'd0, 32'd0, 5'd4, 32'h0000_0108, 1'b0);

    run_op(OP_DIVU, 32'd100, 32'd7, 5'd0, 32'h0000_0200, 1'b0);
    run_op(OP_MFLO, 32'd0, 32'd0, 5'd5, 32'h0000_0204, 1'b0);
    run_op(OP_MFHI, 32'd0, 32'd0, 5'd6, 32'h0000_0208, 1'b0);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, 32'h0000_020C, 1'b0);
    run_op(OP_MFLO, 32'd0, 32'd0, 5'd5, 32'h0000_0210, 1'b0);
    run_op(OP_MFHI, 32'd0, 32'd0, 5'd6, 32'h0000_0214, 1'b0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h0000_0218, 1'b0);
    run_op(OP_MFLO, 32'd0, 32'd0, 5'd5, 32'h0000_021C, 1'b0);
    run_op(OP_MFHI, 32'd0, 32'd0, 5'd6, 32'h0000_0220, 1'b0);
    run_op(OP_DIVU, 32'd5, 32'd0, 5'd0, 32'h0000_0224, 1'b0);
    run_op(OP_MFLO, 32'd0, 32'd0, 5'd5, 32'h0000_0228, 1'b0);
    run_op(OP_MFHI, 32'd0, 32'd0, 5'd6, 32'h0000_022C, 1'b0);

    run_op(OP_MTHI, 32'h0000_1234, 32'd0, 5'd0, 32'h0000_02F0, 1'b0);
    flush_div(10);
    run_op(OP_MFHI, 32'd0, 32'd0, 5'd8, 32'h0000_0304, 1'b0);
    flush_div(DIV_LAT);
    run_op(OP_MFHI, 32'd0, 32'd0, 5'd8, 32'h0000_0308, 1'b0);

    // Output held under back-pressure, then retire and accept on one edge
    model_op(OP_MFLO, 32'd0, 32'd0, er, ew, el);
    issue(OP_MFLO, 32'd0, 32'd0, 5'd9, 32'h0000_0400, 1'b0);
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_result", 64'(out_result), 64'(er));
      chk("hold_pc", 64'(out_pc), 64'h400);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    in_valid  = 1'b1;
    in_op     = OP_MTLO;
    in_src1   = 32'h0000_CAFE;
    in_pc     = 32'h0000_0404;
    out_ready = 1'b1;
    #1;
    chk("both_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    model_op(OP_MTLO, 32'h0000_CAFE, 32'd0, er, ew, el);
    chk("both_valid", 64'(out_valid), 64'd1);
    chk("both_pc", 64'(out_pc), 64'h404);
    chk("both_gr_we", 64'(out_gr_we), 64'd0);
    run_op(OP_MFLO, 32'd0, 32'd0, 5'd10, 32'h0000_0408, 1'b0);

    // Asynchronous reset in the middle of a divide
    issue(OP_DIV, 32'h0000_0055, 32'd3, 5'd0, 32'h0000_0500, 1'b0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    chk("mid_div_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_pc", 64'(out_pc), 64'd0);
    chk("arst_result", 64'(out_result), 64'd0);
    chk("arst_gr_we", 64'(out_gr_we), 64'd0);
    chk("arst_fwd_valid", 64'(fwd_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    hi_m = '0;
    lo_m = '0;
    run_op(OP_MFHI, 32'd0, 32'd0, 5'd11, 32'h0000_0504, 1'b0);
    run_op(OP_MFLO, 32'd0, 32'd0, 5'd12, 32'h0000_0508, 1'b0);

    // Randomized stream with random back-pressure
    for (int n = 0; n < 60; n++) begin
      r    = $urandom_range(0, 9);
      base = 8'h01;
      if (r < 8) op = base << r;
      else if (r == 8) op = 8'h00;
      else op = 8'($urandom) | 8'h11;
      run_op(op, pick(), pick(), 5'($urandom), $urandom, 1'b1);
      if ((op & 8'h0F) != 8'h00 && $countones(op) == 1) begin
        run_op(OP_MFHI, 32'd0, 32'd0, 5'($urandom), $urandom, 1'b1);
        run_op(OP_MFLO, 32'd0, 32'd0, 5'($urandom), $urandom, 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
